// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer with MIPS delay-slot semantics.
// A taken transfer fetches the slot at pc+4, then redirects to the latched target.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        check,
    input  logic        jump,
    input  logic        jr,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] link,
    output logic        in_slot,
    output logic        slot_err
);

    typedef enum logic {
        SEQ,
        SLOT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] tgt_q;
    logic [31:0] tgt_nxt;
    logic [31:0] pc_nxt;
    logic        err_nxt;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] target;
    logic        req;

    assign pc4    = pc + 32'd4;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
    assign req    = jr | jump | check;

    always_comb begin
        target = pc4 + br_off;
        priority case (1'b1)
            jr:      target = jr_target;
            jump:    target = {pc4[31:28], instr_index, 2'b00};
            default: target = pc4 + br_off;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SEQ;
            pc       <= RESET_PC;
            tgt_q    <= 32'd0;
            slot_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            tgt_q    <= tgt_nxt;
            slot_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            unique case (state)
                SEQ:  if (req) state_nxt = SLOT;
                SLOT: state_nxt = SEQ;
                default: state_nxt = SEQ;
            endcase
        end
    end

    // Requests seen in the slot never alter flow; they only raise slot_err.
    always_comb begin
        pc_nxt  = pc;
        tgt_nxt = tgt_q;
        err_nxt = 1'b0;
        if (en) begin
            unique case (state)
                SEQ: begin
                    pc_nxt = pc4;
                    if (req) tgt_nxt = target;
                end
                SLOT: begin
                    pc_nxt  = tgt_q;
                    err_nxt = req;
                end
                default: pc_nxt = pc4;
            endcase
        end
    end

    assign in_slot = (state == SLOT);
    assign link    = pc + 32'd8;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vectors, a behavioural
// model compared every cycle, and literal checks pinning key points.
module tb_pc_sequencer;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        check;
    logic        jump;
    logic        jr;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] link;
    logic        in_slot;
    logic        slot_err;

    int checks = 0;
    int passed = 0;
    bit run = 1'b0;

    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic        m_slot;
    logic        m_err;

    pc_sequencer #(.RESET_PC(RPC)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .check(check),
        .jump(jump),
        .jr(jr),
        .imm16(imm16),
        .instr_index(instr_index),
        .jr_target(jr_target),
        .pc(pc),
        .link(link),
        .in_slot(in_slot),
        .slot_err(slot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] pick(input logic [31:0] a,
                                         input logic r, input logic j,
                                         input logic [15:0] i,
                                         input logic [25:0] x,
                                         input logic [31:0] t);
        logic [31:0] off;
        off = {{16{i[15]}}, i};
        if (r) return t;
        if (j) return ((a + 4) & 32'hF000_0000) | ({6'd0, x} << 2);
        return a + 4 + off * 4;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc   = RPC;
            m_tgt  = 32'd0;
            m_slot = 1'b0;
            m_err  = 1'b0;
        end else if (en) begin
            if (m_slot) begin
                m_err  = jr | jump | check;
                m_pc   = m_tgt;
                m_slot = 1'b0;
            end else begin
                m_err = 1'b0;
                if (jr | jump | check) begin
                    m_tgt  = pick(m_pc, jr, jump, imm16, instr_index, jr_target);
                    m_slot = 1'b1;
                end
                m_pc = m_pc + 4;
            end
        end else begin
            m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (run && !reset) begin
            chk("model_pc", pc, m_pc);
            chk("model_link", link, m_pc + 32'd8);
            chk("model_in_slot", {31'd0, in_slot}, {31'd0, m_slot});
            chk("model_slot_err", {31'd0, slot_err}, {31'd0, m_err});
        end
    end

    task automatic step(input logic e, input logic c, input logic j,
                        input logic r, input logic [15:0] i,
                        input logic [25:0] x, input logic [31:0] t);
        @(negedge clk);
        en          = e;
        check       = c;
        jump        = j;
        jr          = r;
        imm16       = i;
        instr_index = x;
        jr_target   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0; check = 1'b0; jump = 1'b0; jr = 1'b0;
        #2;
        chk("reset_pc", pc, RPC);
        chk("reset_slot", {31'd0, in_slot}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b0; check = 1'b0; jump = 1'b0; jr = 1'b0;
        imm16 = 16'h0; instr_index = 26'h0; jr_target = 32'h0;
        #1 reset = 1'b1;
        #12 reset = 1'b0;
        run = 1'b1;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_link", link, 32'h3008);
        chk("rst_in_slot", {31'd0, in_slot}, 32'd0);
        chk("rst_slot_err", {31'd0, slot_err}, 32'd0);

        idle(); chk("seq1", pc, 32'h3004);
        idle(); chk("seq2", pc, 32'h3008);
        idle(); chk("seq3", pc, 32'h300C);
        chk("seq_link", link, 32'h3014);
        idle(); chk("seq4", pc, 32'h3010);

        step(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 26'h0, 32'h0);
        chk("br_slot_pc", pc, 32'h3014);
        chk("br_slot_flag", {31'd0, in_slot}, 32'd1);
        idle();
        chk("br_tgt_pc", pc, 32'h3010);
        chk("br_tgt_flag", {31'd0, in_slot}, 32'd0);

        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000C10, 32'h0);
        chk("j_slot", pc, 32'h3004);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("j_stall_pc", pc, 32'h3004);
        chk("j_stall_slot", {31'd0, in_slot}, 32'd1);
        idle(); chk("j_tgt", pc, 32'h3040);

        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 26'h0, 32'h0000_4000);
        chk("jr_slot", pc, 32'h3004);
        idle(); chk("jr_wins", pc, 32'h4000);

        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 26'h0, 32'h0);
        chk("err_slot", pc, 32'h4004);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 26'h0, 32'h0);
        chk("err_tgt", pc, 32'h4044);
        chk("err_pulse", {31'd0, slot_err}, 32'd1);
        chk("err_no_slot", {31'd0, in_slot}, 32'd0);
        idle();
        chk("err_clear", {31'd0, slot_err}, 32'd0);
        chk("err_seq", pc, 32'h4048);

        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000100, 32'h0);
        chk("rs_slot", pc, 32'h404C);
        do_reset();
        idle(); chk("rs_resume1", pc, 32'h3004);
        idle(); chk("rs_resume2", pc, 32'h3008);

        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0);
        chk("t4_slot", pc, 32'h300C);
        idle();
        chk("t4_tgt", pc, 32'h300C);
        chk("t4_flag", {31'd0, in_slot}, 32'd0);

        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
        idle(); chk("to_zero", pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFF0, 26'h0, 32'h0);
        idle();
        chk("wrap_neg", pc, 32'hFFFF_FFC4);
        chk("wrap_link", link, 32'hFFFF_FFCC);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'hFFFF_FFFC);
        chk("hi_slot", pc, 32'hFFFF_FFC8);
        idle();
        chk("hi_tgt", pc, 32'hFFFF_FFFC);
        chk("link_wrap", link, 32'h0000_0004);
        idle(); chk("pc_wrap", pc, 32'h0);

        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 26'h3FF_FFFF, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("stall_no_err", {31'd0, slot_err}, 32'd0);
        idle(); chk("jmax", pc, 32'h0FFF_FFFC);
        idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
